// File: rtl/com_from_2_pkg.sv
// Shared types for the bit-serial two's-complement to sign-magnitude converter.
// Holds the FSM state encoding and the default operand width.
package com_from_2_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/Semisumador.sv
// Half adder: s_o = a_i ^ b_i, c_o = a_i & b_i.
// Ports: a_i, b_i operand bits; s_o sum bit; c_o carry out.
module Semisumador (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/com_from_2.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// Ports: clk, rst_n, start, A[N-1:0] in; busy, done, sign, mag[N-1:0] out.
module com_from_2
  import com_from_2_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [N-1:0] mag
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q;
  logic [N-1:0]   shreg_q;
  logic [N-1:0]   mag_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_q;
  logic           carry_q;
  logic           busy_q;
  logic           done_q;

  logic           abit_d;
  logic           sum_d;
  logic           carry_d;

  // Negation is invert-and-add-one: XOR with the sign inverts
  // negative operands, and seeding carry with the sign adds the one.
  assign abit_d = shreg_q[0] ^ sign_q;

  Semisumador u_ha (
    .a_i (abit_d),
    .b_i (carry_q),
    .s_o (sum_d),
    .c_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= A;
            sign_q  <= A[N-1];
            carry_q <= A[N-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q >> 1;
          mag_q   <= {sum_d, mag_q[N-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sign = sign_q;
  assign mag  = mag_q;

endmodule
